// File: rtl/coax_tx_line_encoder_pkg.sv
// coax_tx_line_encoder_pkg: shared state encoding, framing constants and biphase helper
//   state_t    : encoder FSM states
//   biphase()  : line level for a bit value in its first or second half-bit
package coax_tx_line_encoder_pkg;
    localparam int WORD_WIDTH            = 10;
    localparam int CV_HALF_BITS          = 3;
    localparam int END_MINI_CV_HALF_BITS = 2;
    typedef enum logic [2:0] {IDLE, QUIESCE, CV, SYNC, DATA, PAR, END} state_t;
    // A '1' is low-then-high, a '0' is high-then-low.
    function automatic logic biphase(input logic bit_val, input logic second_half);
        return bit_val ? second_half : ~second_half;
    endfunction
endpackage

// File: rtl/coax_tx_line_encoder_if.sv
// coax_tx_line_encoder_if: FIFO handshake and line outputs of the coax transmit encoder
//   data/data_valid/parity : FIFO head word, non-empty flag, parity sense (1 = odd)
//   pop                    : FIFO advance strobe
//   tx/active              : biphase line level and frame-in-progress flag
//   master = FIFO/line side, slave = encoder side
interface coax_tx_line_encoder_if;
    import coax_tx_line_encoder_pkg::*;
    logic [WORD_WIDTH-1:0] data;
    logic                  data_valid;
    logic                  parity;
    logic                  pop;
    logic                  tx;
    logic                  active;
    modport master (output data, data_valid, parity, input pop, tx, active);
    modport slave  (input data, data_valid, parity, output pop, tx, active);
endinterface

// File: rtl/coax_biphase_bit_timer.sv
// coax_biphase_bit_timer: half-bit and bit timing for the biphase serialiser
//   clk, reset_n    : clock, async active-low reset
//   i_clr           : hold timer at the start of a bit (asserted while idle)
//   o_bit_strobe    : last cycle of a bit
//   o_second_half   : currently in the second half-bit
//   o_bit_start     : first cycle of a bit
module coax_biphase_bit_timer #(
    parameter int CLOCKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    output logic o_bit_strobe,
    output logic o_second_half,
    output logic o_bit_start
);
    localparam int HALF = CLOCKS_PER_BIT / 2;
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [HW-1:0] r_hcnt;
    logic          r_second_half;
    logic          w_half_bit_strobe;

    assign w_half_bit_strobe = r_hcnt == HW'(HALF - 1);
    assign o_bit_strobe      = w_half_bit_strobe && r_second_half;
    assign o_second_half     = r_second_half;
    assign o_bit_start       = r_hcnt == '0 && !r_second_half;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcnt        <= '0;
            r_second_half <= 1'b0;
        end else if (i_clr) begin
            r_hcnt        <= '0;
            r_second_half <= 1'b0;
        end else if (w_half_bit_strobe) begin
            r_hcnt        <= '0;
            r_second_half <= ~r_second_half;
        end else begin
            r_hcnt        <= r_hcnt + 1'b1;
        end
    end
endmodule

// File: rtl/coax_tx_line_encoder.sv
// coax_tx_line_encoder: frames FIFO words as a 3270 coax biphase transmission
//   clk, reset_n : clock, async active-low reset
//   io_bus       : FIFO handshake (data, data_valid, parity, pop) and line outputs (tx, active)
//   Frame: QUIESCE_BITS '1's, code violation, per word sync '1' + 10 data bits + parity,
//   then '0' and a two-half-bit mini code violation.
module coax_tx_line_encoder
    import coax_tx_line_encoder_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 8,
    parameter int QUIESCE_BITS   = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    coax_tx_line_encoder_if.slave  io_bus
);
    state_t                r_state, w_next;
    logic [3:0]            r_bcnt;
    logic [WORD_WIDTH-1:0] r_shift;
    logic                  r_pbit;
    logic                  w_bit, w_second, w_start, w_last, w_latch, w_tx, w_pop;
    logic [3:0]            w_limit;
    logic [4:0]            w_hidx;

    coax_biphase_bit_timer #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_timer (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_clr         (r_state == IDLE),
        .o_bit_strobe  (w_bit),
        .o_second_half (w_second),
        .o_bit_start   (w_start)
    );

    // Number of bit periods spent in each state.
    assign w_limit = r_state == QUIESCE ? 4'(QUIESCE_BITS) :
                     r_state == CV      ? 4'(CV_HALF_BITS) :
                     r_state == DATA    ? 4'(WORD_WIDTH) :
                     r_state == END     ? 4'(1 + END_MINI_CV_HALF_BITS / 2) : 4'd1;
    assign w_last  = w_bit && r_bcnt == w_limit - 4'd1;
    assign w_hidx  = {r_bcnt, w_second};
    assign w_latch = r_state == SYNC && w_start;

    always_comb begin
        w_next = r_state;
        w_tx   = 1'b0;
        w_pop  = 1'b0;
        case (r_state)
            IDLE:    w_next = io_bus.data_valid ? QUIESCE : IDLE;
            QUIESCE: begin
                w_tx   = biphase(1'b1, w_second);
                w_next = w_last ? CV : QUIESCE;
            end
            CV: begin
                w_tx   = w_hidx < 5'(CV_HALF_BITS);
                w_next = w_last ? SYNC : CV;
            end
            SYNC: begin
                w_tx   = biphase(1'b1, w_second);
                w_pop  = w_start && io_bus.data_valid;
                w_next = w_last ? DATA : SYNC;
            end
            DATA: begin
                w_tx   = biphase(r_shift[WORD_WIDTH-1], w_second);
                w_next = w_last ? PAR : DATA;
            end
            PAR: begin
                w_tx   = biphase(r_pbit, w_second);
                w_next = !w_last ? PAR : io_bus.data_valid ? SYNC : END;
            end
            END: begin
                // '0' bit, then the line held high for the mini code violation.
                w_tx   = w_hidx >= 5'd2 ? 1'b1 : biphase(1'b0, w_second);
                w_next = w_last ? IDLE : END;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_pbit  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_bcnt  <= w_next != r_state ? 4'd0 :
                       (w_bit && r_bcnt != w_limit - 4'd1) ? r_bcnt + 4'd1 : r_bcnt;
            if (w_latch) begin
                r_shift <= io_bus.data;
                r_pbit  <= ^io_bus.data ^ io_bus.parity;
            end else if (r_state == DATA && w_bit) begin
                r_shift <= {r_shift[WORD_WIDTH-2:0], 1'b0};
            end
        end
    end

    assign io_bus.tx     = w_tx;
    assign io_bus.pop    = w_pop;
    assign io_bus.active = r_state != IDLE;
endmodule

// File: tb/tb_coax_tx_line_encoder.sv
// tb_coax_tx_line_encoder: scoreboard bench comparing the line waveform against a frame model
module tb_coax_tx_line_encoder;
    localparam int CPB      = 8;
    localparam int QB       = 6;
    localparam int HALF     = CPB / 2;
    localparam int MAXH     = 256;
    localparam int POP0     = (QB + 3) * CPB;
    localparam int WORD_CYC = 12 * CPB;

    typedef struct {
        int              nh;
        logic [MAXH-1:0] hb;
        int              npop;
    } frame_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    coax_tx_line_encoder_if bus();

    coax_tx_line_encoder #(.CLOCKS_PER_BIT(CPB), .QUIESCE_BITS(QB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;

    int          tests = 0, fails = 0;
    frame_t      exp_q[$];
    logic [10:0] fifo_q[$];
    bit          en = 0;
    int          drop_pop = 0, pops_seen = 0, stray_pops = 0;
    bit          in_frame = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Expected half-bit sequence of a whole frame; entries are {parity_sense, data}.
    function automatic frame_t make_frame(input logic [10:0] w[$]);
        frame_t f;
        bit     hs[$];
        bit [11:0] b;
        for (int i = 0; i < QB; i++) begin hs.push_back(0); hs.push_back(1); end
        for (int i = 0; i < 6; i++) hs.push_back(i < 3);
        foreach (w[k]) begin
            b = {1'b1, w[k][9:0], 1'(($countones(w[k][9:0]) + int'(w[k][10])) % 2)};
            for (int i = 11; i >= 0; i--) begin hs.push_back(!b[i]); hs.push_back(b[i]); end
        end
        hs.push_back(1); hs.push_back(0); hs.push_back(1); hs.push_back(1);
        f.nh = hs.size();
        f.hb = '0;
        foreach (hs[i]) f.hb[i] = hs[i];
        f.npop = w.size();
        return f;
    endfunction

    task automatic send(input logic [10:0] w[$]);
        fifo_q = w;
        exp_q.push_back(make_frame(w));
        pops_seen = 0;
        en = 1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() > 0 || in_frame || bus.active) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            tests++; fails++;
            $display("FAIL %s: frame not finished, got timeout after %0d cycles, expected completion", name, n);
        end
        en = 0;
        @(negedge clk);
    endtask

    // FIFO model: pop strobe advances the head one edge later.
    initial begin
        bit pend = 0;
        int drop_cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
            pend = 0;
            if (drop_cnt > 0) begin
                drop_cnt--;
                if (drop_cnt == 0) en = 0;
            end
            if (bus.pop === 1'b1) begin
                pend = 1;
                pops_seen++;
                if (pops_seen == drop_pop) drop_cnt = WORD_CYC - 1;
            end
            bus.data_valid = en && fifo_q.size() > 0;
            bus.data       = fifo_q.size() > 0 ? fifo_q[0][9:0] : 10'($urandom);
            bus.parity     = fifo_q.size() > 0 ? fifo_q[0][10] : 1'($urandom);
        end
    end

    // Monitor: collects each frame while active is high and scores it against the queue head.
    initial begin
        int     cyc = 0, mism = 0, pops = 0, badpop = 0;
        bit     unexp = 0;
        frame_t f;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                if (in_frame && !unexp) void'(exp_q.pop_front());
                in_frame = 0;
            end else if (bus.active === 1'b1) begin
                if (!in_frame) begin
                    in_frame = 1; cyc = 0; mism = 0; pops = 0; badpop = 0;
                    unexp = exp_q.size() == 0;
                    if (unexp) begin
                        tests++; fails++;
                        $display("FAIL unexpected_frame: active got 1, expected 0");
                    end else f = exp_q[0];
                end
                if (!unexp) begin
                    if (cyc / HALF >= f.nh || bus.tx !== f.hb[cyc / HALF]) mism++;
                    if (bus.pop === 1'b1) begin
                        if (cyc != POP0 + pops * WORD_CYC) badpop++;
                        pops++;
                    end
                end
                cyc++;
            end else begin
                if (bus.pop !== 1'b0) stray_pops++;
                if (in_frame && !unexp) begin
                    check("frame_len", cyc, f.nh * HALF);
                    check("frame_tx_mismatches", mism, 0);
                    check("frame_pops", pops, f.npop);
                    check("pop_timing_errors", badpop, 0);
                    void'(exp_q.pop_front());
                end
                in_frame = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation got no end, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] w[$];
        logic [10:0] w3[$];
        int cnt;
        repeat (3) @(negedge clk);
        check("reset_tx", int'(bus.tx), 0);
        check("reset_active", int'(bus.active), 0);
        check("reset_pop", int'(bus.pop), 0);
        reset_n = 1;
        repeat (2) @(negedge clk);

        // Single word with start latency.
        w = {};
        w.push_back({1'b1, 10'b0101110101});
        send(w);
        @(negedge clk);
        check("start_active", int'(bus.active), 1);
        repeat (HALF - 1) @(negedge clk);
        check("pre_toggle_tx", int'(bus.tx), 0);
        @(negedge clk);
        check("first_toggle_tx", int'(bus.tx), 1);
        wait_done("single_word");

        // Back-to-back words.
        w = {};
        w.push_back({1'b1, 10'b0101110101});
        w.push_back({1'b1, 10'b1010001110});
        send(w);
        wait_done("back_to_back");

        // Even parity.
        w = {};
        w.push_back({1'b0, 10'b1010001110});
        send(w);
        wait_done("even_parity");

        // Reset during DATA bit 5 (data bit 4 is 0, so the line is high before the abort).
        w = {};
        w.push_back({1'b0, 10'b1100101011});
        send(w);
        cnt = 0;
        while (bus.pop !== 1'b1 && cnt < 1000) begin @(negedge clk); cnt++; end
        check("abort_pop_seen", int'(cnt < 1000), 1);
        repeat (50) @(negedge clk);
        check("pre_abort_tx", int'(bus.tx), 1);
        #2 reset_n = 0;
        #1;
        check("abort_tx", int'(bus.tx), 0);
        check("abort_active", int'(bus.active), 0);
        en = 0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.active !== 1'b0 || bus.pop !== 1'b0) cnt++;
        end
        check("post_abort_idle_errors", cnt, 0);
        check("post_abort_pops", pops_seen, 1);
        check("abort_frame_flushed", exp_q.size(), 0);

        // Valid drops in the last PAR cycle of word 2.
        w = {};
        for (int i = 0; i < 3; i++) w.push_back(11'($urandom));
        w3 = {};
        w3.push_back(w[0]);
        w3.push_back(w[1]);
        fifo_q = w;
        exp_q.push_back(make_frame(w3));
        pops_seen = 0;
        drop_pop = 2;
        en = 1;
        wait_done("valid_drop");
        drop_pop = 0;
        check("drop_pops", pops_seen, 2);
        check("drop_word3_left", fifo_q.size(), 1);
        w3 = {};
        w3.push_back(w[2]);
        exp_q.push_back(make_frame(w3));
        en = 1;
        wait_done("restart_after_drop");

        // Randomized frames.
        for (int k = 0; k < 8; k++) begin
            w = {};
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) w.push_back(11'($urandom));
            if (w.size() == 0) w.push_back(11'($urandom));
            send(w);
            wait_done("random_frame");
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end

        // Idle line.
        en = 0;
        cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.tx !== 1'b0 || bus.active !== 1'b0 || bus.pop !== 1'b0) cnt++;
        end
        check("idle_line_errors", cnt, 0);
        check("stray_pops", stray_pops, 0);
        check("expected_frames_left", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
